// File: rtl/dropout_mask_gen.sv
// Dropout keep-mask generator: Galois LFSR compares one byte per neuron
// against a latched threshold and offers the mask on a valid/ready port.
module dropout_mask_gen #(
  parameter int          N_NEURONS    = 8,
  parameter logic [15:0] SEED_DEFAULT = 16'hACE1,
  parameter bit          MIN_KEEP_EN  = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ena,
  input  logic                 seed_load,
  input  logic [15:0]          seed_in,
  input  logic [7:0]           drop_thresh,
  input  logic                 req,
  output logic                 busy,
  output logic                 mask_valid,
  input  logic                 mask_ready,
  output logic [N_NEURONS-1:0] mask_out,
  output logic [3:0]           keep_cnt
);

  localparam int CW = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1;
  localparam logic [CW-1:0] LAST = CW'(N_NEURONS - 1);

  typedef enum logic [1:0] {
    IDLE,
    GEN,
    FIX,
    HOLD
  } state_t;

  state_t         state, state_d;
  logic [15:0]    lfsr, lfsr_d;
  logic [N_NEURONS-1:0] mask, mask_d;
  logic [CW-1:0]  cnt, cnt_d;
  logic [7:0]     thr, thr_d;
  logic [3:0]     pop_d;

  function automatic logic [15:0] step(input logic [15:0] v);
    return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic logic [3:0] popcnt(
    input logic [N_NEURONS-1:0] v
  );
    logic [3:0] s;
    s = '0;
    for (int i = 0; i < N_NEURONS; i++)
      s = s + 4'(v[i]);
    return s;
  endfunction

  always_comb begin
    state_d = state;
    lfsr_d  = lfsr;
    mask_d  = mask;
    cnt_d   = cnt;
    thr_d   = thr;
    unique case (state)
      IDLE: begin
        if (seed_load) begin
          lfsr_d = (seed_in == 16'h0) ? SEED_DEFAULT : seed_in;
        end else if (req) begin
          thr_d   = drop_thresh;
          mask_d  = '0;
          cnt_d   = '0;
          state_d = GEN;
        end
      end
      GEN: begin
        mask_d[cnt] = (lfsr[7:0] >= thr);
        lfsr_d      = step(lfsr);
        cnt_d       = cnt + 1'b1;
        if (cnt == LAST) begin
          if (MIN_KEEP_EN && mask_d == '0)
            state_d = FIX;
          else
            state_d = HOLD;
        end
      end
      FIX: begin
        // lfsr is not advanced here, so the index is the post-GEN value
        mask_d[lfsr[CW-1:0]] = 1'b1;
        state_d = HOLD;
      end
      HOLD: begin
        if (mask_ready) begin
          if (req) begin
            thr_d   = drop_thresh;
            mask_d  = '0;
            cnt_d   = '0;
            state_d = GEN;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign pop_d = popcnt(mask_d);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      lfsr     <= SEED_DEFAULT;
      mask     <= '0;
      keep_cnt <= '0;
      cnt      <= '0;
      thr      <= '0;
    end else if (ena) begin
      state    <= state_d;
      lfsr     <= lfsr_d;
      mask     <= mask_d;
      keep_cnt <= pop_d;
      cnt      <= cnt_d;
      thr      <= thr_d;
    end
  end

  assign mask_out   = mask;
  assign mask_valid = (state == HOLD);
  assign busy       = (state == GEN) || (state == FIX);

endmodule

// File: tb/tb_dropout_mask_gen.sv
// Directed bench for dropout_mask_gen: latency, masks, FIX repair,
// seeding, backpressure, enable stall and async reset.
module tb_dropout_mask_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        ena;
  logic        seed_load;
  logic [15:0] seed_in;
  logic [7:0]  drop_thresh;
  logic        req;
  logic        busy;
  logic        mask_valid;
  logic        mask_ready;
  logic [7:0]  mask_out;
  logic [3:0]  keep_cnt;

  int tests = 0;
  int failed = 0;
  int n;
  int bc;
  logic [7:0] held;
  logic [7:0] exp_m;

  always #5 clk = ~clk;

  dropout_mask_gen dut (
    .clk         (clk),
    .rst         (rst),
    .ena         (ena),
    .seed_load   (seed_load),
    .seed_in     (seed_in),
    .drop_thresh (drop_thresh),
    .req         (req),
    .busy        (busy),
    .mask_valid  (mask_valid),
    .mask_ready  (mask_ready),
    .mask_out    (mask_out),
    .keep_cnt    (keep_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Ticks until mask_valid (bounded), counting cycles and busy samples.
  task automatic wait_valid(output int cyc, output int bsy);
    cyc = 0;
    bsy = 0;
    while (!mask_valid && cyc < 40) begin
      if (busy) bsy++;
      tick();
      cyc++;
    end
  endtask

  // Reference mask straight from the LFSR polynomial description.
  function automatic logic [7:0] model(input logic [15:0] seed,
                                       input logic [7:0] t);
    logic [15:0] r;
    logic [7:0]  m;
    r = (seed == 16'h0) ? 16'hACE1 : seed;
    m = 8'h00;
    for (int i = 0; i < 8; i++) begin
      m[i] = (r[7:0] >= t);
      r = {1'b0, r[15:1]} ^ (r[0] ? 16'hB400 : 16'h0000);
    end
    if (m == 8'h00) m[r[2:0]] = 1'b1;
    return m;
  endfunction

  task automatic accept(input logic [7:0] t);
    drop_thresh = t;
    req = 1'b1;
    tick();
    req = 1'b0;
  endtask

  task automatic transfer();
    mask_ready = 1'b1;
    tick();
    mask_ready = 1'b0;
  endtask

  task automatic load(input logic [15:0] s);
    seed_in = s;
    seed_load = 1'b1;
    tick();
    seed_load = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    ena = 1'b1;
    seed_load = 1'b0;
    seed_in = 16'h0;
    drop_thresh = 8'h0;
    req = 1'b0;
    mask_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("rst_valid", 32'(mask_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_mask", 32'(mask_out), 32'h00);
    chk("rst_cnt", 32'(keep_cnt), 32'd0);

    // ACE1, thresh 128 hand-computed: bits 0,3,7 kept
    accept(8'd128);
    wait_valid(n, bc);
    chk("t1_lat", n, 8);
    chk("t1_mask", 32'(mask_out), 32'h89);
    chk("t1_cnt", 32'(keep_cnt), 32'd3);
    transfer();
    chk("t1_drop_valid", 32'(mask_valid), 32'd0);
    chk("t1_mask_kept", 32'(mask_out), 32'h89);

    // thresh 0 keeps every neuron
    accept(8'd0);
    wait_valid(n, bc);
    chk("t2_lat", n, 8);
    chk("t2_busy", bc, 8);
    chk("t2_mask", 32'(mask_out), 32'hFF);
    chk("t2_cnt", 32'(keep_cnt), 32'd8);
    transfer();

    // seed 0001 / thresh 255: all dropped, FIX sets bit 0 (lfsr=0168)
    load(16'h0001);
    accept(8'd255);
    wait_valid(n, bc);
    chk("t3_lat", n, 9);
    chk("t3_busy", bc, 9);
    chk("t3_mask", 32'(mask_out), 32'h01);
    chk("t3_cnt", 32'(keep_cnt), 32'd1);
    transfer();

    // zero seed substitutes default; seed_load beats req
    seed_in = 16'h0;
    seed_load = 1'b1;
    req = 1'b1;
    tick();
    seed_load = 1'b0;
    req = 1'b0;
    chk("t4_prio_busy", 32'(busy), 32'd0);
    accept(8'd128);
    wait_valid(n, bc);
    chk("t4_zero_seed", 32'(mask_out), 32'h89);
    transfer();
    load(16'h1234);
    accept(8'd128);
    wait_valid(n, bc);
    exp_m = model(16'h1234, 8'd128);
    chk("t4_seed1234", 32'(mask_out), 32'(exp_m));
    chk("t4_cnt1234", 32'(keep_cnt), 32'($countones(exp_m)));

    // backpressure with req toggling while held
    held = mask_out;
    for (int i = 0; i < 5; i++) begin
      req = i[0];
      tick();
      chk("t5_valid", 32'(mask_valid), 32'd1);
      chk("t5_stable", 32'(mask_out), 32'(held));
    end
    chk("t5_cnt", 32'(keep_cnt), 32'($countones(held)));
    drop_thresh = 8'd0;
    req = 1'b1;
    mask_ready = 1'b1;
    tick();
    req = 1'b0;
    mask_ready = 1'b0;
    chk("t5_b2b_valid", 32'(mask_valid), 32'd0);
    chk("t5_b2b_busy", 32'(busy), 32'd1);
    wait_valid(n, bc);
    chk("t5_b2b_lat", n, 8);
    chk("t5_b2b_mask", 32'(mask_out), 32'hFF);
    transfer();

    // enable stall after four GEN bits
    load(16'hBEEF);
    accept(8'h60);
    for (int i = 0; i < 4; i++) tick();
    ena = 1'b0;
    req = 1'b1;
    drop_thresh = 8'hFF;
    for (int i = 0; i < 3; i++) tick();
    chk("t6_frozen_busy", 32'(busy), 32'd1);
    ena = 1'b1;
    req = 1'b0;
    wait_valid(n, bc);
    chk("t6_lat", n + 7, 11);
    chk("t6_mask", 32'(mask_out), 32'(model(16'hBEEF, 8'h60)));
    ena = 1'b0;
    mask_ready = 1'b1;
    tick();
    chk("t6_no_xfer", 32'(mask_valid), 32'd1);
    ena = 1'b1;
    tick();
    mask_ready = 1'b0;
    chk("t6_xfer", 32'(mask_valid), 32'd0);

    // async reset mid-GEN, then first mask from default seed
    accept(8'd128);
    tick();
    tick();
    rst = 1'b1;
    #2;
    chk("t7_valid", 32'(mask_valid), 32'd0);
    chk("t7_busy", 32'(busy), 32'd0);
    chk("t7_mask", 32'(mask_out), 32'h00);
    chk("t7_cnt", 32'(keep_cnt), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    accept(8'd128);
    wait_valid(n, bc);
    chk("t7_lat", n, 8);
    chk("t7_post_mask", 32'(mask_out), 32'(model(16'hACE1, 8'd128)));
    transfer();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/dropout_mask_gen.md
Name: dropout_mask_gen

Overview:
- Upstream stage for the 8-neuron dropout unit: produces one 8-bit keep mask per request (1 = keep, 0 = drop).
- A 16-bit Galois LFSR generates the mask serially, one neuron per cycle, at a programmable drop rate.
- The result is offered on a valid/ready handshake to the dropout stage, which ANDs it with the neuron data.
- Optionally guarantees at least one kept neuron per mask.

Parameters:
N_NEURONS, 8, mask width; one LFSR step per neuron.
SEED_DEFAULT, 16'hACE1, LFSR value after reset and substitute for a zero seed.
MIN_KEEP_EN, 1, when 1 an all-zero mask is repaired to exactly one kept neuron.

Ports:
clk  in  1  single clock, rising edge.
rst  in  1  asynchronous, active-high reset.
ena  in  1  global enable; low freezes all state.
seed_load  in  1  load seed_in into LFSR (IDLE only).
seed_in  in  16  seed value.
drop_thresh  in  8  drop probability = drop_thresh/256; sampled at request acceptance.
req  in  1  request a new mask.
busy  out  1  high in GEN or FIX.
mask_valid  out  1  mask_out/keep_cnt valid.
mask_ready  in  1  consumer accepts mask.
mask_out  out  N_NEURONS  keep mask.
keep_cnt  out  4  popcount of mask_out.

Behaviour:
- Reset (async, rst=1): state=IDLE, lfsr=SEED_DEFAULT, mask_out=0, keep_cnt=0, mask_valid=0, busy=0, bit counter=0, threshold register=0.
- ena=0: no register changes and no state transitions; handshake inputs are ignored that cycle. Outputs hold.
- LFSR: right-shift Galois. The next value is lfsr>>1, XORed with 16'hB400 when lfsr[0]=1 (x^16+x^14+x^13+x^11). It advances only in GEN.
- IDLE:
  - seed_load=1 loads seed_in; if seed_in=0, SEED_DEFAULT is loaded instead.
  - seed_load has priority over req in the same cycle; req is then ignored.
  - req=1: latch drop_thresh, clear mask and counter, go to GEN.
- GEN (N_NEURONS cycles, counter i=0..7):
  - mask bit i = 1 if lfsr[7:0] >= thresh, else 0.
  - LFSR advances; i increments.
  - After bit 7: go to FIX if MIN_KEEP_EN and the mask is all zero; otherwise go to HOLD.
- FIX (1 cycle): set mask bit lfsr[2:0] to 1, then go to HOLD.
- HOLD:
  - mask_valid=1; mask_out and keep_cnt are stable until transfer.
  - Transfer occurs when mask_ready=1 and ena=1.
  - On transfer: mask_valid drops next cycle and state goes to IDLE. If req=1 in the transfer cycle, state goes directly to GEN (back-to-back), latching the current drop_thresh.
  - mask_out keeps its last value after transfer until the next GEN starts.
- keep_cnt is updated with mask_out (registered popcount) and is valid whenever mask_valid=1.
- Latency, from the req-accept edge to mask_valid=1: 8 cycles (no FIX) or 9 cycles (FIX), assuming ena stays high. Each ena-low cycle adds one.
- Ignored inputs:
  - req while in GEN, FIX or HOLD (except the transfer-cycle case) is ignored; no queueing.
  - seed_load outside IDLE is ignored.
  - drop_thresh changes during GEN have no effect.
- Threshold endpoints:
  - thresh=0: every bit is kept, giving mask 0xFF.
  - thresh=255: a bit is kept only when lfsr[7:0]=0xFF.
- Reset during GEN or HOLD aborts immediately to reset values; a partial mask is never presented.
- busy=1 exactly in GEN and FIX.

Test Plan:
1. Reset: assert rst mid-GEN → next sample shows mask_valid=0, busy=0, mask_out=0x00, keep_cnt=0. First post-reset mask equals the golden model seeded with 16'hACE1.
2. thresh=0, req pulse, mask_ready=1 → mask_valid rises 8 cycles after accept with mask_out=0xFF and keep_cnt=8; busy high for exactly 8 cycles.
3. thresh=255, MIN_KEEP_EN=1, seed 16'h0001 (all 8 bytes drop) → FIX taken, mask_valid at 9 cycles, exactly one bit set (index = lfsr[2:0] at FIX), keep_cnt=1.
4. seed_load=1 with seed_in=0 in IDLE, then thresh=128 request → mask equals the golden model run from 16'hACE1 (zero-seed substitution). A second run with seed 16'h1234 matches the model from 16'h1234.
5. Backpressure: mask_ready=0 for 5 cycles in HOLD with req toggling → mask_valid stays 1 and mask_out/keep_cnt stay stable. On ready=1 with req=1: transfer, then GEN immediately (busy=1 next cycle).
6. ena=0 for 3 cycles mid-GEN (after bit 3) → LFSR, counter and state frozen; mask_valid arrives 11 cycles after accept, with the same mask as an uninterrupted run.
